memoria_principal: RTL and testbench
====================================

Name: memoria_principal

Overview:
- Backing-store responder on the memory side of the 2-way data cache.
- Services the cache's line-fill reads and write-back writes over a request/complete handshake, with a fixed, parameterised access latency.
- Holds one word per address in a register array, initialised to the cache's "empty" pattern.
- Keeps saturating read and write access counters for the debug display.

Parameters:
- LARGURA_DADO, 8, data word width in bits.
- LARGURA_END, 5, address width; array depth is 2**LARGURA_END.
- LATENCIA, 3, cycles from request acceptance to completion; legal range 1..15.
- VALOR_INICIAL, 8'hFF, array contents after reset.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- pedido  input  1  request valid (level); sampled only in OCIOSO.
- escrita  input  1  request type: 1 = write, 0 = read.
- endereco  input  LARGURA_END  request address.
- entradaDeDados  input  LARGURA_DADO  write data.
- aceito  output  1  one-cycle pulse: request captured.
- ocupado  output  1  high while a request is in flight.
- pronto  output  1  one-cycle pulse: request completed.
- saidaDeDados  output  LARGURA_DADO  read data, or echoed write data.
- contadorLeituras  output  8  completed reads, saturating.
- contadorEscritas  output  8  completed writes, saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = OCIOSO; aceito, ocupado, pronto = 0.
  - saidaDeDados = 0; both counters = 0; every array word = VALOR_INICIAL.
  - Any in-flight request is dropped with no pronto.
  - First capture is possible on the first rising edge after reset=1.
- States: OCIOSO, ESPERA. Internal registers: captured endereco, escrita and data; 4-bit countdown contador.
- OCIOSO, with pedido=1 at edge k:
  - Capture the request and load contador = LATENCIA-1.
  - Go to ESPERA; aceito=1 and ocupado=1 for the cycle after edge k.
  - With pedido=0, remain in OCIOSO; aceito=0 and ocupado=0.
- ESPERA, contador != 0: decrement contador; aceito=0; ocupado stays 1.
- ESPERA, contador == 0 (completion edge, k+LATENCIA):
  - Read: saidaDeDados = array[captured endereco], the value current at this edge.
  - Write: array[captured endereco] = captured data; saidaDeDados = captured data.
  - pronto=1 for exactly one cycle; ocupado=0.
  - Increment contadorLeituras or contadorEscritas; each holds at 255.
  - Return to OCIOSO.
- Latency: pronto is seen exactly LATENCIA cycles after aceito rises. With LATENCIA=1, pronto follows aceito directly.
- saidaDeDados holds its value until the next completion or reset.
- No queue: pedido is ignored while in ESPERA. The requester holds pedido high until aceito.
- While pronto=1 the block is in OCIOSO. A pedido sampled at the following edge is accepted, so back-to-back throughput is one request per LATENCIA+1 cycles.
- pedido held high continuously: a new request is captured on the edge after each pronto.
- Input values other than pedido at non-capture edges are don't-care.
- Read after write to the same address returns the new data; the write commits at its completion edge, before any later capture.
- Address wrap: none. endereco spans the full array exactly.

Test Plan:
- Reset release, then read address 5 with pedido held -> aceito at cycle 1; pronto exactly 3 cycles later; saidaDeDados=8'hFF; contadorLeituras=1.
- Write 8'h3C to address 2, then read address 2 -> write pronto with saidaDeDados=8'h3C; read returns 8'h3C; contadorEscritas=1, contadorLeituras=1.
- pedido held high for 4 reads of addresses 0..3 -> captures spaced 4 cycles apart; no request lost or duplicated; no aceito while ocupado=1.
- Drop reset to 0 asynchronously mid-ESPERA of a write of 8'hA5 to address 7 -> outputs clear immediately; no pronto; a later read of address 7 returns 8'hFF.
- LATENCIA=1 build, write then read address 31 -> pronto one cycle after each aceito; read returns the written data.
- 260 writes -> contadorEscritas saturates at 255 and stays there; contadorLeituras remains 0.

Source files
------------

// File: rtl/memoria_principal.sv
// Backing store for the 2-way data cache: fixed-latency line-fill reads and
// write-back writes over a pedido/aceito/pronto handshake, plus access counters.
module memoria_principal #(
    parameter int                      LARGURA_DADO  = 8,
    parameter int                      LARGURA_END   = 5,
    parameter int                      LATENCIA      = 3,
    parameter logic [LARGURA_DADO-1:0] VALOR_INICIAL = 8'hFF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    pedido,
    input  logic                    escrita,
    input  logic [LARGURA_END-1:0]  endereco,
    input  logic [LARGURA_DADO-1:0] entradaDeDados,
    output logic                    aceito,
    output logic                    ocupado,
    output logic                    pronto,
    output logic [LARGURA_DADO-1:0] saidaDeDados,
    output logic [7:0]              contadorLeituras,
    output logic [7:0]              contadorEscritas
);

    localparam int         PROFUNDIDADE = 2 ** LARGURA_END;
    localparam logic [3:0] CARGA        = 4'(LATENCIA - 1);

    // Handshake: pedido is a level sampled only in OCIOSO; aceito pulses for
    // the cycle after capture, ocupado covers the whole ESPERA window, and
    // pronto pulses once the access has committed (block is back in OCIOSO).
    typedef enum logic {
        OCIOSO = 1'b0,
        ESPERA = 1'b1
    } estado_t;

    estado_t                 estado_q, estado_d;
    logic [3:0]              contador_q, contador_d;
    logic [LARGURA_END-1:0]  end_q, end_d;
    logic                    esc_q, esc_d;
    logic [LARGURA_DADO-1:0] dado_q, dado_d;
    logic                    aceito_q, aceito_d;
    logic                    pronto_q, pronto_d;
    logic [LARGURA_DADO-1:0] saida_q, saida_d;
    logic [7:0]              leit_q, leit_d;
    logic [7:0]              escr_q, escr_d;
    logic                    grava;
    logic [LARGURA_DADO-1:0] mem_q [PROFUNDIDADE];

    always_comb begin
        estado_d   = estado_q;
        contador_d = contador_q;
        end_d      = end_q;
        esc_d      = esc_q;
        dado_d     = dado_q;
        aceito_d   = 1'b0;
        pronto_d   = 1'b0;
        saida_d    = saida_q;
        leit_d     = leit_q;
        escr_d     = escr_q;
        grava      = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (pedido) begin
                    estado_d   = ESPERA;
                    contador_d = CARGA;
                    end_d      = endereco;
                    esc_d      = escrita;
                    dado_d     = entradaDeDados;
                    aceito_d   = 1'b1;
                end
            end
            ESPERA: begin
                if (contador_q != 4'd0) begin
                    contador_d = contador_q - 4'd1;
                end else begin
                    estado_d = OCIOSO;
                    pronto_d = 1'b1;
                    if (esc_q) begin
                        grava   = 1'b1;
                        saida_d = dado_q;
                        if (escr_q != 8'hFF) escr_d = escr_q + 8'd1;
                    end else begin
                        saida_d = mem_q[end_q];
                        if (leit_q != 8'hFF) leit_d = leit_q + 8'd1;
                    end
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            contador_q <= 4'd0;
            end_q      <= '0;
            esc_q      <= 1'b0;
            dado_q     <= '0;
            aceito_q   <= 1'b0;
            pronto_q   <= 1'b0;
            saida_q    <= '0;
            leit_q     <= 8'd0;
            escr_q     <= 8'd0;
        end else begin
            estado_q   <= estado_d;
            contador_q <= contador_d;
            end_q      <= end_d;
            esc_q      <= esc_d;
            dado_q     <= dado_d;
            aceito_q   <= aceito_d;
            pronto_q   <= pronto_d;
            saida_q    <= saida_d;
            leit_q     <= leit_d;
            escr_q     <= escr_d;
        end
    end

    // The array is a plain register file so reset can restore the "empty" pattern.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PROFUNDIDADE; i++) mem_q[i] <= VALOR_INICIAL;
        end else if (grava) begin
            mem_q[end_q] <= dado_q;
        end
    end

    assign aceito           = aceito_q;
    assign ocupado          = (estado_q == ESPERA);
    assign pronto           = pronto_q;
    assign saidaDeDados     = saida_q;
    assign contadorLeituras = leit_q;
    assign contadorEscritas = escr_q;

endmodule

// File: tb/tb_memoria_principal.sv
// Directed bench for memoria_principal: a LATENCIA=3 instance and a LATENCIA=1
// instance share stimulus; sel chooses which one is driven and observed.
module tb_memoria_principal;

    logic       clock = 1'b0;
    logic       reset;
    logic       sel;
    logic       pedido;
    logic       escrita;
    logic [4:0] endereco;
    logic [7:0] dado;

    logic       aceito0, ocupado0, pronto0;
    logic [7:0] saida0, leit0, escr0;
    logic       aceito1, ocupado1, pronto1;
    logic [7:0] saida1, leit1, escr1;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    memoria_principal #(.LATENCIA(3)) dut (
        .clock(clock), .reset(reset), .pedido(pedido & ~sel), .escrita(escrita),
        .endereco(endereco), .entradaDeDados(dado), .aceito(aceito0),
        .ocupado(ocupado0), .pronto(pronto0), .saidaDeDados(saida0),
        .contadorLeituras(leit0), .contadorEscritas(escr0)
    );

    memoria_principal #(.LATENCIA(1)) dut_l1 (
        .clock(clock), .reset(reset), .pedido(pedido & sel), .escrita(escrita),
        .endereco(endereco), .entradaDeDados(dado), .aceito(aceito1),
        .ocupado(ocupado1), .pronto(pronto1), .saidaDeDados(saida1),
        .contadorLeituras(leit1), .contadorEscritas(escr1)
    );

    logic       o_aceito, o_ocupado, o_pronto;
    logic [7:0] o_saida, o_leit, o_escr;
    assign o_aceito  = sel ? aceito1  : aceito0;
    assign o_ocupado = sel ? ocupado1 : ocupado0;
    assign o_pronto  = sel ? pronto1  : pronto0;
    assign o_saida   = sel ? saida1   : saida0;
    assign o_leit    = sel ? leit1    : leit0;
    assign o_escr    = sel ? escr1    : escr0;

    task automatic check(input string nome, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nome, got, exp);
        end
    endtask

    // One request on the selected instance: expect aceito one edge after pedido,
    // ocupado throughout, pronto exactly lat cycles after aceito, then the data.
    task automatic req(input logic esc, input logic [4:0] a, input logic [7:0] d,
                       input int lat, input logic [7:0] exp, input string nome);
        int n;
        pedido = 1'b1; escrita = esc; endereco = a; dado = d;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!o_aceito && n < 20);
        check({nome, " aceito"}, n, 1);
        pedido = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            n++;
            if (o_pronto) break;
            check({nome, " ocupado"}, int'(o_ocupado), 1);
        end
        check({nome, " latencia"}, n, lat);
        check({nome, " ocupado fim"}, int'(o_ocupado), 0);
        check({nome, " saida"}, int'(o_saida), int'(exp));
    endtask

    typedef struct {
        logic       esc;
        logic [4:0] a;
        logic [7:0] d;
        logic [7:0] exp;
        logic [7:0] exp_l;
        logic [7:0] exp_e;
    } vec_t;

    vec_t       tab [8];
    logic [7:0] exp_q [$];
    logic [7:0] held_exp [4];

    initial begin
        int acc, done, last, model;
        logic [7:0] e;

        tab[0] = '{1'b0, 5'd5,  8'h00, 8'hFF, 8'd1, 8'd0};
        tab[1] = '{1'b1, 5'd2,  8'h3C, 8'h3C, 8'd1, 8'd1};
        tab[2] = '{1'b0, 5'd2,  8'h99, 8'h3C, 8'd2, 8'd1};
        tab[3] = '{1'b1, 5'd31, 8'h5A, 8'h5A, 8'd2, 8'd2};
        tab[4] = '{1'b0, 5'd31, 8'h00, 8'h5A, 8'd3, 8'd2};
        tab[5] = '{1'b0, 5'd0,  8'h11, 8'hFF, 8'd4, 8'd2};
        tab[6] = '{1'b1, 5'd0,  8'h00, 8'h00, 8'd4, 8'd3};
        tab[7] = '{1'b0, 5'd0,  8'h77, 8'h00, 8'd5, 8'd3};
        held_exp[0] = 8'h00; held_exp[1] = 8'hFF;
        held_exp[2] = 8'h3C; held_exp[3] = 8'hFF;

        reset = 1'b0; sel = 1'b0; pedido = 1'b0; escrita = 1'b0;
        endereco = '0; dado = '0;
        repeat (2) @(negedge clock);
        check("reset aceito",  int'(aceito0),  0);
        check("reset ocupado", int'(ocupado0), 0);
        check("reset pronto",  int'(pronto0),  0);
        check("reset saida",   int'(saida0),   0);
        check("reset leit",    int'(leit0),    0);
        check("reset escr",    int'(escr0),    0);
        check("reset l1 saida", int'(saida1),  0);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            req(tab[i].esc, tab[i].a, tab[i].d, 3, tab[i].exp, $sformatf("vec%0d", i));
            check($sformatf("vec%0d leit", i), int'(o_leit), int'(tab[i].exp_l));
            check($sformatf("vec%0d escr", i), int'(o_escr), int'(tab[i].exp_e));
        end

        // pedido held high across four reads of addresses 0..3
        pedido = 1'b1; escrita = 1'b0; endereco = 5'd0;
        acc = 0; done = 0; last = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clock);
            if (o_aceito) begin
                if (acc > 0) check("held espaco", c - last, 4);
                last = c;
                exp_q.push_back(held_exp[acc]);
                acc++;
                endereco = 5'(acc);
                if (acc == 4) pedido = 1'b0;
            end
            if (o_pronto) begin
                if (exp_q.size() == 0) begin
                    check("held pronto extra", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("held saida", int'(o_saida), int'(e));
                end
                done++;
                if (done == 4) break;
            end
        end
        check("held aceitos", acc, 4);
        check("held prontos", done, 4);
        check("held leit", int'(o_leit), 9);

        // asynchronous reset in the middle of a write
        pedido = 1'b1; escrita = 1'b1; endereco = 5'd7; dado = 8'hA5;
        @(negedge clock);
        check("rst aceito", int'(o_aceito), 1);
        pedido = 1'b0;
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("rst ocupado", int'(ocupado0), 0);
        check("rst aceito0", int'(aceito0), 0);
        check("rst pronto",  int'(pronto0),  0);
        check("rst saida",   int'(saida0),   0);
        check("rst leit",    int'(leit0),    0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("rst sem pronto", int'(o_pronto), 0);
        end
        req(1'b0, 5'd7, 8'h00, 3, 8'hFF, "rst le7");
        check("rst escr", int'(o_escr), 0);

        // LATENCIA=1 instance: saturation of the write counter, then address 31
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        sel = 1'b1;
        model = 0;
        for (int i = 0; i < 260; i++) begin
            req(1'b1, 5'(i), 8'(i), 1, 8'(i), "sat");
            model = (model == 255) ? 255 : model + 1;
            check("sat escr", int'(o_escr), model);
        end
        check("sat escr final", int'(o_escr), 255);
        check("sat leit", int'(o_leit), 0);
        req(1'b1, 5'd31, 8'hC7, 1, 8'hC7, "l1 esc31");
        req(1'b0, 5'd31, 8'h00, 1, 8'hC7, "l1 le31");
        check("l1 leit", int'(o_leit), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
